// File: rtl/instr_step_sequencer_pkg.sv
// Shared definitions for the instruction step sequencer: state codes, opcodes,
// bus mux sources and IR field positions. MULDIV_EN adds the T6 state.
package cpu_ctrl_pkg;

  localparam int OPC_W  = 5;
  localparam int RSEL_W = 4;

  localparam int IR_OPC_HI = 31;
  localparam int IR_OPC_LO = 27;
  localparam int IR_RA_HI  = 26;
  localparam int IR_RA_LO  = 23;
  localparam int IR_RB_HI  = 22;
  localparam int IR_RB_LO  = 19;
  localparam int IR_RC_HI  = 18;
  localparam int IR_RC_LO  = 15;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
`ifdef MULDIV_EN
    S_T6   = 4'd7,
`endif
    S_HALT = 4'd8
  } state_t;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  localparam logic [4:0] BUS_R0     = 5'd0;
  localparam logic [4:0] BUS_HI     = 5'd16;
  localparam logic [4:0] BUS_LO     = 5'd17;
  localparam logic [4:0] BUS_ZHIGH  = 5'd18;
  localparam logic [4:0] BUS_ZLOW   = 5'd19;
  localparam logic [4:0] BUS_PC     = 5'd20;
  localparam logic [4:0] BUS_MDR    = 5'd21;
  localparam logic [4:0] BUS_INPORT = 5'd22;
  localparam logic [4:0] BUS_CSIGN  = 5'd23;

endpackage

// File: rtl/instr_step_sequencer_if.sv
// Control bundle between the step sequencer (master) and the bus datapath (slave).
interface instr_step_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic              start;
  logic              mem_ready;
  logic [31:0]       ir_q;
  logic [4:0]        bus_sel;
  logic [15:0]       reg_in;
  logic              pc_in, inc_pc, mar_in, mdr_in, mem_read, ir_load;
  logic              y_in, z_in, hi_in, lo_in;
  logic [OPC_W-1:0]  alu_op;
  logic              halted, mem_timeout, illegal_op;
  logic [3:0]        state_q;

  modport master (
    input  start, mem_ready, ir_q,
    output bus_sel, reg_in, pc_in, inc_pc, mar_in, mdr_in, mem_read, ir_load,
           y_in, z_in, hi_in, lo_in, alu_op, halted, mem_timeout, illegal_op, state_q
  );

  modport slave (
    output start, mem_ready, ir_q,
    input  bus_sel, reg_in, pc_in, inc_pc, mar_in, mdr_in, mem_read, ir_load,
           y_in, z_in, hi_in, lo_in, alu_op, halted, mem_timeout, illegal_op, state_q
  );
endinterface

// File: rtl/instr_step_sequencer_ir_field_decode.sv
// Combinational IR field split and opcode classification.
// MUL/DIV count as ALU operations only when MULDIV_EN is defined.
module ir_field_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [IR_OPC_HI:IR_RC_LO] ir_q,
  output logic [OPC_W-1:0]          opcode,
  output logic [RSEL_W-1:0]         ra,
  output logic [RSEL_W-1:0]         rb,
  output logic [RSEL_W-1:0]         rc,
  output logic                      is_alu,
  output logic                      is_muldiv,
  output logic                      is_nop,
  output logic                      is_halt,
  output logic                      is_illegal
);

  assign opcode = ir_q[IR_OPC_HI:IR_OPC_LO];
  assign ra     = ir_q[IR_RA_HI:IR_RA_LO];
  assign rb     = ir_q[IR_RB_HI:IR_RB_LO];
  assign rc     = ir_q[IR_RC_HI:IR_RC_LO];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    is_alu     = 1'b0;
    is_muldiv  = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu = 1'b1;
      OP_MUL, OP_DIV: begin
`ifdef MULDIV_EN
        is_alu    = 1'b1;
        is_muldiv = 1'b1;
`else
        is_illegal = 1'b1;
`endif
      end
      OP_NOP:  is_nop  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_step_sequencer.sv
// Fetch/execute step sequencer driving the shared-bus datapath through T0-T5.
// Define MULDIV_EN to enable MUL/DIV with the extra T6 (HI write) step.
module instr_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_step_sequencer_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nx;
  logic               timeout_flag, set_timeout;
  logic [OPC_W-1:0]   opcode;
  logic [RSEL_W-1:0]  ra, rb, rc;
  logic               is_alu, is_muldiv, is_nop, is_halt, is_illegal;
  state_t             end_next;

  ir_field_decode u_decode (
    .ir_q       (bus.ir_q[IR_OPC_HI:IR_RC_LO]),
    .opcode     (opcode),
    .ra         (ra),
    .rb         (rb),
    .rc         (rc),
    .is_alu     (is_alu),
    .is_muldiv  (is_muldiv),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (set_timeout) timeout_flag <= 1'b1;
    end
  end

  // start is re-sampled at every instruction boundary.
  assign end_next = bus.start ? S_T0 : S_IDLE;

  assign bus.state_q     = state;
  assign bus.halted      = (state == S_HALT);
  assign bus.mem_timeout = timeout_flag;

  always_comb begin
    state_nx       = state;
    wait_cnt_nx    = wait_cnt;
    set_timeout    = 1'b0;
    bus.bus_sel    = BUS_R0;
    bus.reg_in     = '0;
    bus.pc_in      = 1'b0;
    bus.inc_pc     = 1'b0;
    bus.mar_in     = 1'b0;
    bus.mdr_in     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.ir_load    = 1'b0;
    bus.y_in       = 1'b0;
    bus.z_in       = 1'b0;
    bus.hi_in      = 1'b0;
    bus.lo_in      = 1'b0;
    bus.alu_op     = '0;
    bus.illegal_op = 1'b0;

    case (state)
      S_IDLE: if (bus.start) state_nx = S_T0;
      S_T0: begin
        bus.bus_sel = BUS_PC;
        bus.mar_in  = 1'b1;
        bus.inc_pc  = 1'b1;
        bus.z_in    = 1'b1;
        state_nx    = S_T1;
      end
      S_T1: begin
        bus.bus_sel  = BUS_ZLOW;
        bus.mem_read = 1'b1;
        bus.mdr_in   = 1'b1;
        bus.pc_in    = (wait_cnt == '0);
        // A ready on the final allowed cycle still completes the fetch.
        if (bus.mem_ready) begin
          wait_cnt_nx = '0;
          state_nx    = S_T2;
        end else if (wait_cnt == CNT_LAST) begin
          wait_cnt_nx = '0;
          set_timeout = 1'b1;
          state_nx    = S_HALT;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      S_T2: begin
        bus.bus_sel = BUS_MDR;
        bus.ir_load = 1'b1;
        state_nx    = S_T3;
      end
      S_T3: begin
        if (is_alu) begin
          bus.bus_sel = {1'b0, rb};
          bus.y_in    = 1'b1;
          state_nx    = S_T4;
        end else if (is_halt) begin
          state_nx = S_HALT;
        end else begin
          bus.illegal_op = is_illegal;
          state_nx       = end_next;
        end
      end
      S_T4: begin
        bus.bus_sel = {1'b0, rc};
        bus.alu_op  = opcode;
        bus.z_in    = 1'b1;
        state_nx    = S_T5;
      end
      S_T5: begin
        bus.bus_sel = BUS_ZLOW;
        if (is_muldiv) begin
          bus.lo_in = 1'b1;
`ifdef MULDIV_EN
          state_nx  = S_T6;
`else
          state_nx  = end_next;
`endif
        end else begin
          bus.reg_in[ra] = 1'b1;
          state_nx       = end_next;
        end
      end
`ifdef MULDIV_EN
      S_T6: begin
        bus.bus_sel = BUS_ZHIGH;
        bus.hi_in   = 1'b1;
        state_nx    = end_next;
      end
`endif
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_step_sequencer.sv
// Randomized scoreboard bench for instr_step_sequencer: an instruction-level model
// expands each instruction into per-cycle expected outputs checked by a monitor.
module tb_instr_step_sequencer;
  import cpu_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0]  bus_sel;
    logic [15:0] reg_in;
    logic        pc_in, inc_pc, mar_in, mdr_in, mem_read, ir_load;
    logic        y_in, z_in, hi_in, lo_in;
    logic [4:0]  alu_op;
    logic        halted, mem_timeout, illegal_op;
    logic [3:0]  state_q;
  } out_t;

  typedef struct {
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;
    out_t        exp;
  } cyc_t;

  localparam int K_ALU = 0, K_MULDIV = 1, K_NOP = 2, K_HALT = 3, K_ILL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_step_sequencer_if bus_if ();
  instr_step_sequencer #(.MEM_TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  cyc_t stim_q[$];
  out_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc_n = 0;
  logic prev_cont;

  function automatic out_t sample();
    out_t o;
    o.bus_sel = bus_if.bus_sel;   o.reg_in = bus_if.reg_in;
    o.pc_in = bus_if.pc_in;       o.inc_pc = bus_if.inc_pc;
    o.mar_in = bus_if.mar_in;     o.mdr_in = bus_if.mdr_in;
    o.mem_read = bus_if.mem_read; o.ir_load = bus_if.ir_load;
    o.y_in = bus_if.y_in;         o.z_in = bus_if.z_in;
    o.hi_in = bus_if.hi_in;       o.lo_in = bus_if.lo_in;
    o.alu_op = bus_if.alu_op;     o.halted = bus_if.halted;
    o.mem_timeout = bus_if.mem_timeout; o.illegal_op = bus_if.illegal_op;
    o.state_q = bus_if.state_q;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int classify(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b01001, 5'b01010: return K_ALU;
`ifdef MULDIV_EN
      5'b01111, 5'b10000: return K_MULDIV;
`endif
      5'b11010: return K_NOP;
      5'b11011: return K_HALT;
      default:  return K_ILL;
    endcase
  endfunction

  function automatic logic [4:0] pick_op();
    logic [4:0] ops [6] = '{5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01111, 5'b10000};
    int r = $urandom_range(0, 7);
    logic [4:0] op;
    if (r < 6) return ops[r];
    if (r == 6) return 5'b11010;
    do op = 5'($urandom); while (classify(op) != K_ILL);
    return op;
  endfunction

  function automatic out_t base(input logic [3:0] st, input logic [4:0] bsel);
    out_t o = '0;
    o.state_q = st;
    o.bus_sel = bsel;
    return o;
  endfunction

  task automatic push(input logic s, input logic mr, input logic [31:0] ir, input out_t e);
    cyc_t c;
    c.start = s; c.mem_ready = mr; c.ir = ir; c.exp = e;
    stim_q.push_back(c);
  endtask

  task automatic gen_idle(input int n);
    repeat (n) push(1'b0, 1'($urandom), $urandom, base(S_IDLE, 5'd0));
    push(1'b1, 1'($urandom), $urandom, base(S_IDLE, 5'd0));
  endtask

  task automatic gen_fetch(input int waits);
    out_t o;
    o = base(S_T0, 5'd20); o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
    push(1'($urandom), 1'($urandom), $urandom, o);
    for (int i = 0; i <= waits; i++) begin
      o = base(S_T1, 5'd19); o.mem_read = 1; o.mdr_in = 1; o.pc_in = (i == 0);
      push(1'($urandom), (i == waits), $urandom, o);
    end
  endtask

  // One instruction: fetch with `waits` not-ready T1 cycles, then execute.
  // cont is the start value seen on the final step; cut stops after T4.
  task automatic gen_instr(input logic [31:0] ir, input int waits, input logic cont, input bit cut);
    out_t o;
    logic [4:0] op = ir[31:27];
    logic [3:0] ra = ir[26:23];
    logic [3:0] rb = ir[22:19];
    logic [3:0] rc = ir[18:15];
    int k = classify(op);
    gen_fetch(waits);
    o = base(S_T2, 5'd21); o.ir_load = 1;
    push(1'($urandom), 1'($urandom), ir, o);
    o = base(S_T3, 5'd0);
    if (k == K_ALU || k == K_MULDIV) begin
      o.bus_sel = {1'b0, rb}; o.y_in = 1;
      push(1'($urandom), 1'($urandom), ir, o);
    end else if (k == K_HALT) begin
      push(1'($urandom), 1'($urandom), ir, o);
      repeat (3) begin
        o = base(S_HALT, 5'd0); o.halted = 1;
        push(1'($urandom), 1'($urandom), $urandom, o);
      end
      return;
    end else begin
      o.illegal_op = (k == K_ILL);
      push(cont, 1'($urandom), ir, o);
      return;
    end
    o = base(S_T4, {1'b0, rc}); o.alu_op = op; o.z_in = 1;
    push(1'($urandom), 1'($urandom), ir, o);
    if (cut) return;
    o = base(S_T5, 5'd19);
    if (k == K_MULDIV) begin
`ifdef MULDIV_EN
      o.lo_in = 1;
      push(1'($urandom), 1'($urandom), ir, o);
      o = base(S_T6, 5'd18); o.hi_in = 1;
      push(cont, 1'($urandom), ir, o);
`endif
    end else begin
      o.reg_in = 16'h0001 << ra;
      push(cont, 1'($urandom), ir, o);
    end
  endtask

  task automatic gen_program(input int n, input bit end_halt);
    for (int i = 0; i < n; i++) begin
      logic [31:0] ir;
      int w;
      logic cont;
      ir = $urandom;
      w = $urandom_range(0, 4);
      ir[31:27] = pick_op();
      if (i == 0 && !end_halt) begin ir = 32'h4A920000; w = 0; end
      if (i == 1) ir[31:27] = 5'b11111;
      if (i == 2) ir[31:27] = 5'b11010;
      if (i == 3) w = 3;
      if (i == 4) w = 15;
      if (i == 5) ir[31:27] = 5'b01111;
      if (end_halt && i == n - 1) ir[31:27] = 5'b11011;
      cont = (i == n - 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (!prev_cont) gen_idle($urandom_range(0, 2));
      gen_instr(ir, w, cont, 1'b0);
      prev_cont = cont;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 64'(stim_q.size() + exp_q.size()), 64'd0);
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic reset_check(input string name);
    rst = 1'b0;
    #1;
    check(name, 64'(sample()), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    prev_cont = 1'b0;
  endtask

  // Driver: applies the next cycle's inputs and hands its expectation to the monitor.
  initial begin
    cyc_t c;
    bus_if.start = 1'b0;
    bus_if.mem_ready = 1'b0;
    bus_if.ir_q = '0;
    forever begin
      @(posedge clk); #1;
      if (stim_q.size() > 0) begin
        c = stim_q.pop_front();
        bus_if.start = c.start;
        bus_if.mem_ready = c.mem_ready;
        bus_if.ir_q = c.ir;
        exp_q.push_back(c.exp);
      end else begin
        bus_if.start = 1'b0;
        bus_if.mem_ready = 1'b0;
      end
    end
  end

  // Monitor: compares the full output vector mid-cycle.
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle_%0d_state_%0d", cyc_n, e.state_q), 64'(sample()), 64'(e));
      end
    end
  end

  initial begin
    out_t o;
    #1;
    check("reset_state", 64'(sample()), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    prev_cont = 1'b0;

    gen_program(40, 1'b0);
    drain("drain_random");

    gen_idle(0);
    gen_instr({5'b00011, 27'($urandom)}, 1, 1'b1, 1'b1);
    drain("drain_to_t4");
    reset_check("reset_mid_t4");

    gen_program(6, 1'b1);
    drain("drain_halt_op");
    reset_check("reset_after_halt");

    gen_idle(1);
    o = base(S_T0, 5'd20); o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
    push(1'b1, 1'b0, $urandom, o);
    for (int i = 0; i < 16; i++) begin
      o = base(S_T1, 5'd19); o.mem_read = 1; o.mdr_in = 1; o.pc_in = (i == 0);
      push(1'($urandom), 1'b0, $urandom, o);
    end
    repeat (4) begin
      o = base(S_HALT, 5'd0); o.halted = 1; o.mem_timeout = 1;
      push(1'($urandom), 1'($urandom), $urandom, o);
    end
    drain("drain_timeout");
    reset_check("reset_after_timeout");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", tests_failed);
    $fatal(1);
  end

endmodule
